// File: rtl/shift_pipe_if.sv
// shift_pipe_if: request/result bundle for shift_pipe (flush, in_* request side, out_* result side).
// Latency: none, this is wiring only.
// Backpressure: valid/ready on both sides; in_ready and out_valid are driven by the shifter.
// Signals: flush, in_valid/in_ready/in_data/in_amt/in_op/in_tag, out_valid/out_ready/out_data/out_tag/out_zero.
// Modports: master = producer of operations / consumer of results, slave = the shifter.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int L = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [L-1:0]     in_amt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport master (
        output flush, in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport slave (
        input  flush, in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR), one registered 2^n stage per amount bit.
// Latency: log2(WIDTH) registers; an op offered and taken in cycle c shows out_valid in cycle c+log2(WIDTH).
// Backpressure: global stall, every stage holds while out_valid && !out_ready; in_ready drops with it.
// Ports: clk (rising edge), rst_n (async, active-low), bus (shift_pipe_if.slave):
//   flush drops everything in flight; in_* offers an operation; out_* presents the result,
//   out_zero flags an all-zero result.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_pipe_if.slave bus
);
    localparam int L = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic advance;

    // Bubbles are kept: the whole pipe moves or the whole pipe holds.
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance && !bus.flush;

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int SH = 1 << (L - 1 - k);  // shift distance of this stage
        localparam int RW = L - 1 - k;         // amount bits still pending after this stage

        logic             src_vld;
        logic [WIDTH-1:0] src_dat;
        logic [1:0]       src_op;
        logic [RW:0]      src_amt;  // MSB is this stage's amount bit
        logic [TAG_W-1:0] src_tag;

        logic [WIDTH-1:0] dat_d;

        logic             vld_q;
        logic [WIDTH-1:0] dat_q;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_src
            assign src_vld = bus.in_valid && bus.in_ready;
            assign src_dat = bus.in_data;
            assign src_op  = bus.in_op;
            assign src_amt = bus.in_amt;
            assign src_tag = bus.in_tag;
        end else begin : g_src
            assign src_vld = g_stage[k-1].vld_q;
            assign src_dat = g_stage[k-1].dat_q;
            assign src_op  = g_stage[k-1].g_fwd.op_q;
            assign src_amt = g_stage[k-1].g_fwd.amt_q;
            assign src_tag = g_stage[k-1].tag_q;
        end

        // SRA fills from the current MSB; every earlier stage already kept the
        // sign there, so the cascade equals one sign-filled shift of the operand.
        always_comb begin
            dat_d = src_dat;
            if (src_amt[RW]) begin
                case (src_op)
                    OP_SLL:  dat_d = {src_dat[WIDTH-SH-1:0], {SH{1'b0}}};
                    OP_SRL:  dat_d = {{SH{1'b0}}, src_dat[WIDTH-1:SH]};
                    OP_SRA:  dat_d = {{SH{src_dat[WIDTH-1]}}, src_dat[WIDTH-1:SH]};
                    default: dat_d = {src_dat[SH-1:0], src_dat[WIDTH-1:SH]};
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                dat_q <= '0;
                tag_q <= '0;
            end else begin
                if (bus.flush) begin
                    vld_q <= 1'b0;
                end else if (advance) begin
                    vld_q <= src_vld;
                end
                // Payload follows the pipe even for bubbles; only vld_q qualifies it.
                if (advance) begin
                    dat_q <= dat_d;
                    tag_q <= src_tag;
                end
            end
        end

        // The last stage needs neither the op nor any amount bits downstream.
        if (k < L - 1) begin : g_fwd
            logic [1:0]    op_q;
            logic [RW-1:0] amt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_q  <= '0;
                    amt_q <= '0;
                end else if (advance) begin
                    op_q  <= src_op;
                    amt_q <= src_amt[RW-1:0];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[L-1].vld_q;
    assign bus.out_data  = g_stage[L-1].dat_q;
    assign bus.out_tag   = g_stage[L-1].tag_q;
    assign bus.out_zero  = (g_stage[L-1].dat_q == '0);
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the CPU datapath: shift-left logical, shift-right logical, shift-right arithmetic and rotate-right on a WIDTH-bit operand.
- Built as log2(WIDTH) registered shift stages, first stage shifting by WIDTH/2 and the last by 1.
- Valid/ready handshakes on both sides, a sideband tag and a synchronous flush.
- Sits between the register-read stage and writeback; replaces the single-stage fixed-amount shifters, which are combinational and one-directional.

## Interface
- WIDTH, 32, operand width; power of two, 4..64; L = log2(WIDTH).
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; drops all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_amt  in  L  shift amount, 0..WIDTH-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  high when out_data == 0.

## Operation
- L stages, each holding a register set: valid, data, op, remaining amount bits, tag.
- Stage k (k = 0..L-1) applies a shift of 2^(L-1-k) when amount bit L-1-k is set; otherwise it passes the data through.
- Fill rules per stage:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: copies of the current MSB enter at the MSB. Because each stage preserves the sign, the result equals the original operand shifted with sign fill.
  - ROR: bits leaving at the LSB re-enter at the MSB.
- Amount 0 returns the operand unchanged for every op.
- Global stall: advance = !out_valid || out_ready.
  - When advance is high, every stage loads from the stage before it, and stage 0 loads from the inputs.
  - When advance is low, all stages hold.
- in_ready = advance && !flush, combinational.
- Bubbles are not squeezed out. A stalled pipe holds its empty slots as well.
- Stage 0 valid loads in_valid && in_ready; data fields load unconditionally when advance is high.
- out_data, out_tag, out_valid and out_zero are the registered outputs of stage L-1. out_zero is computed combinationally from the stage L-1 data register.
- Results leave in acceptance order. No operation is lost or duplicated under any out_ready pattern.
- flush: on the clock edge where it is sampled high, all valid bits clear. No input is accepted in that cycle, and out_valid is 0 from the next cycle on. flush takes priority over both advance and in_valid.

## Timing
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+L (5 cycles for WIDTH=32), provided there is no stall.
- Throughput: one operation per cycle while out_ready stays high.
- Stall: while out_valid && !out_ready, all outputs hold stable and in_ready = 0. The pipe resumes the cycle after out_ready rises, and the held result completes its transfer on that edge.
- Reset (rst_n low, at any time, including mid-operation):
  - All valid bits clear immediately and asynchronously.
  - out_valid = 0, out_data = 0, out_tag = 0, so out_zero = 1.
  - in_ready = 1 (provided flush = 0).
  - In-flight operations are discarded.
  - The first accept is possible on the first edge after rst_n rises.
- Simultaneous events:
  - Output consume and input accept in the same cycle are both legal, and the pipe advances.
  - flush in the same cycle as out_ready: the result at the output counts as consumed if out_valid was high; all other in-flight operations are dropped.
- in_amt >= WIDTH cannot occur, since the port is L bits wide.
- No combinational path from in_* to out_*. The only combinational path is from out_ready and flush to in_ready.

## Test plan
- Reset, WIDTH=32: after rst_n rises, out_valid = 0, out_data = 0, out_zero = 1, in_ready = 1. Then SRA 0x80000000 by 16 with tag 3 -> 0xFFFF8000 and tag 3, with out_valid exactly 5 cycles after accept.
- Op sweep, each for amounts 0, 1, 31:
  - SLL 0x00000001 by 31 -> 0x80000000.
  - SRL 0x80000000 by 31 -> 0x00000001.
  - SRA 0x7FFFFFFF by 31 -> 0x00000000 with out_zero = 1.
  - ROR 0x12345678 by 8 -> 0x78123456.
  - Amount 0 -> operand unchanged.
- Backpressure:
  - Stimulus: 6 back-to-back ops (tags 0..5); once tag 0 appears, hold out_ready low for 3 cycles.
  - Required: out_data and out_tag stable, in_ready = 0 for those 3 cycles; all 6 results then delivered in order with no gaps once out_ready is high.
- Flush: 3 ops in flight plus flush asserted together with in_valid -> no results emerge, that input is not accepted, out_valid = 0 the cycle after flush.
- Async reset mid-operation: drop rst_n between edges with 4 ops in flight -> out_valid falls without waiting for a clock edge, and no stale result appears after reset.
- Random soak, WIDTH=8 and WIDTH=64: random ops, amounts and ready/valid toggling against a reference model -> every result and tag matches, in order.
